// File: rtl/uart_loader_ctrl.sv
// Command sequencer between the UART receiver and instruction memory / debug control.
// Decodes LOAD/RUN/STEP opcodes; LOAD streams big-endian 32-bit words into memory from address 0.
module uart_loader_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  CMD_LOAD = 8'h01,
  parameter logic [7:0]  CMD_RUN  = 8'h02,
  parameter logic [7:0]  CMD_STEP = 8'h03
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              run_pulse,
  output logic              step_pulse,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StGetLen, StGetBytes} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [CntW-1:0]   tmo_cnt_q;
  logic              timeout_hit;
  logic [ADDR_W-1:0] len_in;

  assign timeout_hit = (tmo_cnt_q == CntW'(TIMEOUT - 1));
  assign len_in      = ADDR_W'(rx_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      tmo_cnt_q  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      run_pulse  <= 1'b0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      run_pulse  <= 1'b0;
      step_pulse <= 1'b0;
      load_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tmo_cnt_q <= '0;
          if (rx_done_tick) begin
            if (rx_data == CMD_LOAD) begin
              state_q    <= StGetLen;
              busy       <= 1'b1;
              err        <= 1'b0;
              word_idx_q <= '0;
            end else if (rx_data == CMD_RUN) begin
              run_pulse <= 1'b1;
            end else if (rx_data == CMD_STEP) begin
              step_pulse <= 1'b1;
            end
          end
        end
        StGetLen: begin
          // A byte on the expiry cycle takes priority over the timeout.
          if (rx_done_tick) begin
            tmo_cnt_q <= '0;
            len_q     <= len_in;
            if (len_in == '0) begin
              load_done <= 1'b1;
              busy      <= 1'b0;
              state_q   <= StIdle;
            end else begin
              byte_idx_q <= '0;
              state_q    <= StGetBytes;
            end
          end else if (timeout_hit) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
          end
        end
        StGetBytes: begin
          if (rx_done_tick) begin
            tmo_cnt_q  <= '0;
            word_q     <= {word_q[15:0], rx_data};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= word_idx_q;
              mem_wdata  <= {word_q, rx_data};
              word_idx_q <= word_idx_q + ADDR_W'(1);
              if (word_idx_q == len_q - ADDR_W'(1)) begin
                load_done <= 1'b1;
                busy      <= 1'b0;
                state_q   <= StIdle;
              end
            end
          end else if (timeout_hit) begin
            // Partial word is dropped; words already written stay written.
            err        <= 1'b1;
            busy       <= 1'b0;
            byte_idx_q <= '0;
            state_q    <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
